// File: rtl/ft_tx_channel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ft_tx_channel_arbiter
//  Description : Round-robin merge of NUM_CHANNELS byte-wide Avalon-ST
//                requester streams into a single stream feeding an FT245
//                bridge sink. One channel holds the grant until its packet
//                ends or MAX_BURST beats have been forwarded. A cut packet
//                re-enters arbitration and continues on a later grant.
//
//  Optional    : FT_ARB_HEADER_EN -- when defined, every grant begins with
//                one header beat {4'hA, channel} (SOP=1). When undefined,
//                the stream carries payload only and the first data beat of
//                each grant carries SOP.
//
//  Ports       : clk               sole clock, rising edge
//                reset             synchronous, active-high
//                in_data           per-channel byte, channel i at [8i+7:8i]
//                in_valid          per-channel valid
//                in_startofpacket  per-channel SOP (not used for framing)
//                in_endofpacket    per-channel EOP
//                in_ready          per-channel ready (granted channel only)
//                out_data/valid/startofpacket/endofpacket
//                                  registered merged stream
//                out_ready         downstream ready
//                grant_channel     index of the granted channel
//                busy              high whenever the FSM is not idle
//
//  Revision    : 1.0 - initial release
// ============================================================================
module ft_tx_channel_arbiter #(
    parameter int NUM_CHANNELS = 4,
    parameter int MAX_BURST    = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [8*NUM_CHANNELS-1:0] in_data,
    input  logic [NUM_CHANNELS-1:0]   in_valid,
    input  logic [NUM_CHANNELS-1:0]   in_startofpacket,
    input  logic [NUM_CHANNELS-1:0]   in_endofpacket,
    output logic [NUM_CHANNELS-1:0]   in_ready,
    output logic [7:0]                out_data,
    output logic                      out_valid,
    output logic                      out_startofpacket,
    output logic                      out_endofpacket,
    input  logic                      out_ready,
    output logic [3:0]                grant_channel,
    output logic                      busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HEADER = 2'd1,
        S_DATA   = 2'd2
    } state_t;

    localparam logic [11:0] c_LAST_BEAT = 12'(MAX_BURST - 1);
    localparam logic [3:0]  c_LAST_CH   = 4'(NUM_CHANNELS - 1);

    state_t      r_state;
    logic [3:0]  r_grant;
    logic [3:0]  r_rr_ptr;
    logic [11:0] r_count;
    logic [7:0]  r_out_data;
    logic        r_out_valid;
    logic        r_out_sop;
    logic        r_out_eop;

    // Inputs widened to the 16-channel maximum so a 4-bit channel index
    // always selects within range regardless of NUM_CHANNELS.
    logic [15:0]  w_valid_pad;
    logic [15:0]  w_eop_pad;
    logic [127:0] w_data_pad;

    logic         w_found;
    logic [3:0]   w_sel;
    logic [4:0]   w_idx;
    logic [7:0]   w_cur_data;
    logic         w_cur_valid;
    logic         w_cur_eop;
    logic         w_out_free;
    logic         w_accept;
    logic         w_last;
    logic         w_unused_sop;

    assign w_valid_pad = 16'(in_valid);
    assign w_eop_pad   = 16'(in_endofpacket);
    assign w_data_pad  = 128'(in_data);

    // Framing is derived from the grant itself, so requester SOP is ignored.
    assign w_unused_sop = ^in_startofpacket;

    // First valid channel at or after r_rr_ptr in circular order. The loop
    // runs from the farthest offset down so the nearest hit wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = 4'd0;
        w_idx   = 5'd0;
        for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_rr_ptr} + 5'(k);
            if (w_idx >= 5'(NUM_CHANNELS)) begin
                w_idx = w_idx - 5'(NUM_CHANNELS);
            end
            if (w_valid_pad[w_idx[3:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[3:0];
            end
        end
    end

    assign w_cur_data  = w_data_pad[{r_grant, 3'b000} +: 8];
    assign w_cur_valid = w_valid_pad[r_grant];
    assign w_cur_eop   = w_eop_pad[r_grant];

    // The output register can take a new beat when it is empty or its
    // current beat is being consumed this cycle.
    assign w_out_free = ~r_out_valid | out_ready;
    assign w_accept   = (r_state == S_DATA) & w_cur_valid & w_out_free;
    assign w_last     = w_cur_eop | (r_count == c_LAST_BEAT);

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if ((r_state == S_DATA) && (r_grant == 4'(i))) begin
                in_ready[i] = w_out_free;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_grant     <= 4'd0;
            r_rr_ptr    <= 4'd0;
            r_count     <= 12'd0;
            r_out_data  <= 8'd0;
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
        end else begin
            // Held beat retires when sampled with out_ready; a load below
            // overrides this.
            if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant  <= w_sel;
                        r_rr_ptr <= (w_sel == c_LAST_CH) ? 4'd0 : w_sel + 4'd1;
                        r_count  <= 12'd0;
`ifdef FT_ARB_HEADER_EN
                        r_state  <= S_HEADER;
`else
                        r_state  <= S_DATA;
`endif
                    end
                end

`ifdef FT_ARB_HEADER_EN
                S_HEADER: begin
                    if (w_out_free) begin
                        r_out_data  <= {4'hA, r_grant};
                        r_out_valid <= 1'b1;
                        r_out_sop   <= 1'b1;
                        r_out_eop   <= 1'b0;
                        r_state     <= S_DATA;
                    end
                end
`endif

                S_DATA: begin
                    if (w_accept) begin
                        r_out_data  <= w_cur_data;
                        r_out_valid <= 1'b1;
`ifdef FT_ARB_HEADER_EN
                        r_out_sop   <= 1'b0;
`else
                        r_out_sop   <= (r_count == 12'd0);
`endif
                        // A burst cut is marked as a packet end downstream.
                        r_out_eop   <= w_last;
                        r_count     <= r_count + 12'd1;
                        if (w_last) begin
                            r_state <= S_IDLE;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out_data          = r_out_data;
    assign out_valid         = r_out_valid;
    assign out_startofpacket = r_out_sop;
    assign out_endofpacket   = r_out_eop;
    assign grant_channel     = r_grant;
    assign busy              = (r_state != S_IDLE);

endmodule
`default_nettype wire
